// File: rtl/led_test_ctrl.sv
// LED pattern generator: a free-running tick divider drives either an 8-bit
// binary counter or a bouncing one-hot scanner onto the LEDs, selected by KEY[1].
module led_test_ctrl #(
   parameter int NUM_COUNT = 50000000
) (
   input  logic       CLOCK_50,
   input  logic [1:0] KEY,
   output logic [7:0] LED
);

   localparam int CW = ($clog2(NUM_COUNT) < 1) ? 1 : $clog2(NUM_COUNT);
   localparam logic [CW-1:0] LAST = CW'(NUM_COUNT - 1);

   logic          w_rst;
   logic          w_tick;
   logic [CW-1:0] count_r;
   logic          r_sync1;
   logic          mode_sync;
   logic [7:0]    bin_r;
   logic [7:0]    scan_r;
   logic          dir_r;
   logic [7:0]    r_led;
   logic [7:0]    w_bin_next;
   logic [7:0]    w_scan_next;
   logic          w_dir_next;

   assign w_rst      = KEY[0];
   assign w_tick     = (count_r == LAST);
   assign w_bin_next = bin_r + 8'd1;

   // Scanner bounces off either end instead of wrapping.
   always_comb begin
      w_scan_next = scan_r;
      w_dir_next  = dir_r;
      if (!dir_r) begin
         if (scan_r == 8'h80) begin
            w_scan_next = 8'h40;
            w_dir_next  = 1'b1;
         end else begin
            w_scan_next = scan_r << 1;
         end
      end else begin
         if (scan_r == 8'h01) begin
            w_scan_next = 8'h02;
            w_dir_next  = 1'b0;
         end else begin
            w_scan_next = scan_r >> 1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (w_rst) begin
         count_r   <= '0;
         r_sync1   <= 1'b0;
         mode_sync <= 1'b0;
         bin_r     <= 8'h00;
         scan_r    <= 8'h01;
         dir_r     <= 1'b0;
         r_led     <= 8'h00;
      end else begin
         count_r   <= w_tick ? '0 : count_r + CW'(1);
         r_sync1   <= KEY[1];
         mode_sync <= r_sync1;
         // Mode is only sampled on tick; the idle pattern keeps its state.
         if (w_tick) begin
            if (mode_sync) begin
               scan_r <= w_scan_next;
               dir_r  <= w_dir_next;
               r_led  <= w_scan_next;
            end else begin
               bin_r  <= w_bin_next;
               r_led  <= w_bin_next;
            end
         end
      end
   end

   assign LED = r_led;

endmodule

// File: tb/tb_led_test_ctrl.sv
// Randomized bench for led_test_ctrl (NUM_COUNT=5): a cycle-level reference model
// pushes expected count/LED per clock edge; a monitor pops and compares each cycle.
module tb_led_test_ctrl;

   localparam int N = 5;

   typedef struct {
      int         count;
      logic [7:0] led;
      bit         tick;
   } exp_t;

   logic       clk = 1'b0;
   logic [1:0] key = 2'b01;
   logic [7:0] led;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   done     = 0;

   // Reference model state: position in the period, binary value, scanner step.
   int         m_count = 0;
   int         m_bin   = 0;
   int         m_pos   = 0;
   logic [7:0] m_led   = 8'h00;
   bit         m_k1    = 0;
   bit         m_k2    = 0;
   bit         cur_k   = 0;

   led_test_ctrl #(.NUM_COUNT(N)) dut (
      .CLOCK_50 (clk),
      .KEY      (key),
      .LED      (led)
   );

   always #5 clk = ~clk;

   // Scanner as a 14-step round trip: 01,02,...,80,40,...,02, then back to 01.
   function automatic logic [7:0] scan_pat(input int p);
      int b;
      b = (p < 8) ? p : 14 - p;
      return 8'(1 << b);
   endfunction

   // Drive one clock edge's inputs and record what the design must show after it.
   task automatic step(input bit rst, input bit k1);
      exp_t e;
      bit   tick;
      key  = {k1, rst};
      tick = 0;
      if (rst) begin
         m_count = 0; m_bin = 0; m_pos = 0; m_led = 8'h00; m_k1 = 0; m_k2 = 0;
      end else begin
         tick = (m_count == N - 1);
         if (tick) begin
            if (m_k2) begin
               m_pos = (m_pos + 1) % 14;
               m_led = scan_pat(m_pos);
            end else begin
               m_bin = (m_bin + 1) % 256;
               m_led = 8'(m_bin);
            end
         end
         m_count = (m_count + 1) % N;
         m_k2 = m_k1;
         m_k1 = k1;
      end
      e.count = m_count;
      e.led   = m_led;
      e.tick  = tick;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expected record per edge, compared at the following falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL queue_empty: got led=%02h count=%0d, required a pending expectation", led, dut.count_r);
            end else begin
               e = exp_q.pop_front();
               if (led !== e.led) begin
                  n_errors++;
                  $display("FAIL led: got %02h, required %02h at %0t", led, e.led, $time);
               end
               n_checks++;
               if (int'(dut.count_r) != e.count) begin
                  n_errors++;
                  $display("FAIL count_r: got %0d, required %0d at %0t", dut.count_r, e.count, $time);
               end
               if (e.tick)
                  $display("tick t=%0t led=%02h expected=%02h", $time, led, e.led);
            end
         end
      end
   end

   initial begin
      int nrst;
      // Binary mode from reset, long enough to wrap FF -> 00.
      step(1, 0);
      step(1, 0);
      for (int i = 0; i < 257 * N + 3; i++) step(0, 0);

      // Scanner mode from reset release, several full bounces.
      step(1, 1);
      step(1, 1);
      cur_k = 1;
      for (int i = 0; i < 32 * N; i++) step(0, 1);

      // Reset asserted with the period at count 3.
      for (int i = 0; i < 2 * N && m_count != 3; i++) step(0, cur_k);
      step(1, cur_k);
      for (int i = 0; i < 3 * N; i++) step(0, cur_k);

      // Random mode toggles (mid-period, near ticks) and sporadic resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) cur_k = ~cur_k;
         if ($urandom_range(0, 199) == 0) begin
            nrst = $urandom_range(1, 3);
            for (int j = 0; j < nrst; j++) step(1, cur_k);
         end else begin
            step(0, cur_k);
         end
      end

      @(negedge clk);
      #1;
      done = 1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
